// File: rtl/step_motor_ctrl_top.sv
// Unipolar 4-coil stepper controller: continuous run at 10..60 RPM, full/half step,
// one-shot quarter turn while idle, RPM tens digit on an active-low seven-segment display.
module step_motor_ctrl_top #(
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned STEPS_PER_REV = 200
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       direction,
  input  logic       speed_sel,
  input  logic       on,
  input  logic       quarter,
  input  logic       step_size,
  output logic [6:0] sev_seg_o,
  output logic [6:0] sev_seg_t,
  output logic [3:0] pulses_out
);

  localparam logic [63:0] NumFull = 64'(CLK_HZ) * 64'd60;
  localparam logic [63:0] NumHalf = 64'(CLK_HZ) * 64'd30;
  localparam logic [63:0] Spr     = 64'(STEPS_PER_REV);
  localparam logic [15:0] QFull   = 16'(STEPS_PER_REV / 4);
  localparam logic [15:0] QHalf   = 16'(STEPS_PER_REV / 2);

  function automatic logic [3:0] phase(input logic [2:0] i);
    logic [3:0] p;
    unique case (i)
      3'd0: p = 4'b0001;
      3'd1: p = 4'b0011;
      3'd2: p = 4'b0010;
      3'd3: p = 4'b0110;
      3'd4: p = 4'b0100;
      3'd5: p = 4'b1100;
      3'd6: p = 4'b1000;
      3'd7: p = 4'b1001;
    endcase
    return p;
  endfunction

  function automatic logic [6:0] seg(input logic [2:0] d);
    logic [6:0] s;
    case (d)
      3'd2:    s = 7'b0100100;
      3'd3:    s = 7'b0110000;
      3'd4:    s = 7'b0011001;
      3'd5:    s = 7'b0010010;
      3'd6:    s = 7'b0000010;
      default: s = 7'b1111001;
    endcase
    return s;
  endfunction

  // rpm_q holds RPM/10 (1..6)
  logic [2:0]  rpm_q, rpm_d, rpm_nxt;
  logic        up_q, up_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] timer_q, timer_d;
  logic [3:0]  pulses_q, pulses_d;
  logic [6:0]  seg_t_q, seg_t_d;
  logic        busy_q, busy_d, dwell_q, dwell_d;
  logic        qdir_q, qdir_d, qfull_q, qfull_d;
  logic [15:0] qcnt_q, qcnt_d;
  logic        spd_cur_q, spd_prev_q, qtr_cur_q, qtr_prev_q, on_prev_q;

  logic        speed_edge, quarter_edge, on_rise;
  logic        active, eff_dir, eff_full, step_evt, advance;
  logic [31:0] p_full, p_half, period;

  assign speed_edge   = spd_cur_q & ~spd_prev_q;
  assign quarter_edge = qtr_cur_q & ~qtr_prev_q;
  assign on_rise      = on & ~on_prev_q;
  assign active       = on | busy_q;
  // A quarter turn uses the mode latched at its press, not the live inputs
  assign eff_dir      = busy_q ? qdir_q : direction;
  assign eff_full     = busy_q ? qfull_q : step_size;

  // Step period lookup; every arm divides constants only, so no divider is built
  always_comb begin
    p_full = 32'(NumFull / (64'd10 * Spr));
    p_half = 32'(NumHalf / (64'd10 * Spr));
    case (rpm_q)
      3'd2: begin p_full = 32'(NumFull / (64'd20 * Spr)); p_half = 32'(NumHalf / (64'd20 * Spr)); end
      3'd3: begin p_full = 32'(NumFull / (64'd30 * Spr)); p_half = 32'(NumHalf / (64'd30 * Spr)); end
      3'd4: begin p_full = 32'(NumFull / (64'd40 * Spr)); p_half = 32'(NumHalf / (64'd40 * Spr)); end
      3'd5: begin p_full = 32'(NumFull / (64'd50 * Spr)); p_half = 32'(NumHalf / (64'd50 * Spr)); end
      3'd6: begin p_full = 32'(NumFull / (64'd60 * Spr)); p_half = 32'(NumHalf / (64'd60 * Spr)); end
      default: ;
    endcase
    period = eff_full ? p_full : p_half;
  end

  assign step_evt = active & (timer_q >= period - 32'd1);
  // The dwell-ending step releases the coils instead of moving
  assign advance  = step_evt & ~(busy_q & dwell_q);

  // Next-state: speed ping-pong, quarter-turn sequencing, timer, phase index, outputs
  always_comb begin
    rpm_d    = rpm_q;
    rpm_nxt  = rpm_q;
    up_d     = up_q;
    idx_d    = idx_q;
    timer_d  = timer_q;
    busy_d   = busy_q;
    dwell_d  = dwell_q;
    qdir_d   = qdir_q;
    qfull_d  = qfull_q;
    qcnt_d   = qcnt_q;

    if (speed_edge) begin
      rpm_nxt = up_q ? rpm_q + 3'd1 : rpm_q - 3'd1;
      rpm_d   = rpm_nxt;
      if (rpm_nxt == 3'd6) up_d = 1'b0;
      else if (rpm_nxt == 3'd1) up_d = 1'b1;
    end

    if (on_rise && busy_q) begin
      busy_d  = 1'b0;
      dwell_d = 1'b0;
      qcnt_d  = '0;
    end else if (quarter_edge && !on && !busy_q) begin
      busy_d  = 1'b1;
      dwell_d = 1'b0;
      qcnt_d  = '0;
      qdir_d  = direction;
      qfull_d = step_size;
    end else if (step_evt && busy_q) begin
      if (dwell_q) begin
        busy_d  = 1'b0;
        dwell_d = 1'b0;
        qcnt_d  = '0;
      end else begin
        qcnt_d = qcnt_q + 16'd1;
        if (qcnt_q + 16'd1 == (qfull_q ? QFull : QHalf)) dwell_d = 1'b1;
      end
    end

    if (!active || step_evt) timer_d = '0;
    else                     timer_d = timer_q + 32'd1;

    if (advance) begin
      if (!eff_full)    idx_d = eff_dir ? idx_q + 3'd1 : idx_q - 3'd1;
      else if (eff_dir) idx_d = (idx_q | 3'd1) + 3'd1;
      else              idx_d = (idx_q - 3'd1) & 3'b110;
    end

    pulses_d = active ? phase(idx_q) : 4'b0000;
    seg_t_d  = seg(rpm_q);
  end

  // State registers with asynchronous clear to the power-on configuration
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rpm_q      <= 3'd1;
      up_q       <= 1'b1;
      idx_q      <= '0;
      timer_q    <= '0;
      pulses_q   <= '0;
      seg_t_q    <= 7'b1111001;
      busy_q     <= 1'b0;
      dwell_q    <= 1'b0;
      qdir_q     <= 1'b0;
      qfull_q    <= 1'b0;
      qcnt_q     <= '0;
      spd_cur_q  <= 1'b0;
      spd_prev_q <= 1'b0;
      qtr_cur_q  <= 1'b0;
      qtr_prev_q <= 1'b0;
      on_prev_q  <= 1'b0;
    end else begin
      rpm_q      <= rpm_d;
      up_q       <= up_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      pulses_q   <= pulses_d;
      seg_t_q    <= seg_t_d;
      busy_q     <= busy_d;
      dwell_q    <= dwell_d;
      qdir_q     <= qdir_d;
      qfull_q    <= qfull_d;
      qcnt_q     <= qcnt_d;
      spd_cur_q  <= speed_sel;
      spd_prev_q <= spd_cur_q;
      qtr_cur_q  <= quarter;
      qtr_prev_q <= qtr_cur_q;
      on_prev_q  <= on;
    end
  end

  // Speed is always a multiple of ten, so the ones digit is fixed at '0'
  assign sev_seg_o  = 7'b1000000;
  assign sev_seg_t  = seg_t_q;
  assign pulses_out = pulses_q;

endmodule

// File: tb/tb_step_motor_ctrl_top.sv
// Directed bench for step_motor_ctrl_top at CLK_HZ=1200, STEPS_PER_REV=20.
module tb_step_motor_ctrl_top;

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic       direction = 1'b1;
  logic       speed_sel = 1'b0;
  logic       on = 1'b0;
  logic       quarter = 1'b0;
  logic       step_size = 1'b1;
  logic [6:0] sev_seg_o, sev_seg_t;
  logic [3:0] pulses_out;

  int checks = 0;
  int errors = 0;

  step_motor_ctrl_top #(
    .CLK_HZ       (1200),
    .STEPS_PER_REV(20)
  ) dut (
    .clk       (clk),
    .resetb    (resetb),
    .direction (direction),
    .speed_sel (speed_sel),
    .on        (on),
    .quarter   (quarter),
    .step_size (step_size),
    .sev_seg_o (sev_seg_o),
    .sev_seg_t (sev_seg_t),
    .pulses_out(pulses_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       dir;
    logic       full;
    logic [3:0] exp;
    int         gap;
  } vec_t;

  vec_t       vecs[11];
  logic [6:0] spd_exp[11];
  logic [3:0] qtr_exp[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Count clocks until pulses_out changes; a timeout returns the unchanged value
  task automatic wait_change(input int limit, output int n, output logic [3:0] val);
    logic [3:0] prev;
    prev = pulses_out;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pulses_out == prev && n < limit);
    val = pulses_out;
  endtask

  task automatic press_speed();
    speed_sel = 1'b1;
    @(negedge clk);
    speed_sel = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  int         n;
  int         bad;
  logic [3:0] val;

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 4'b0010, 360};
    vecs[1]  = '{1'b1, 1'b1, 4'b0100, 360};
    vecs[2]  = '{1'b1, 1'b1, 4'b1000, 360};
    vecs[3]  = '{1'b1, 1'b1, 4'b0001, 360};
    vecs[4]  = '{1'b1, 1'b1, 4'b0010, 360};
    vecs[5]  = '{1'b1, 1'b0, 4'b0110, 180};
    vecs[6]  = '{1'b1, 1'b0, 4'b0100, 180};
    vecs[7]  = '{1'b1, 1'b0, 4'b1100, 180};
    vecs[8]  = '{1'b0, 1'b0, 4'b0100, 180};
    vecs[9]  = '{1'b0, 1'b0, 4'b0110, 180};
    vecs[10] = '{1'b0, 1'b0, 4'b0010, 180};
    spd_exp  = '{7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b0010010,
                 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b0100100};
    qtr_exp  = '{4'b0011, 4'b0010, 4'b0110, 4'b0100, 4'b1100,
                 4'b1000, 4'b1001, 4'b0001, 4'b0011, 4'b0010};

    // Reset state
    on = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_pulses", 32'(pulses_out), 32'h0);
    check("reset_seg_t", 32'(sev_seg_t), 32'(7'b1111001));
    check("reset_seg_o", 32'(sev_seg_o), 32'(7'b1000000));
    resetb = 1'b1;
    @(negedge clk);
    check("first_phase", 32'(pulses_out), 32'h1);

    // Full-step CW, then half-step CW, then half-step CCW
    for (int i = 0; i < 11; i++) begin
      direction = vecs[i].dir;
      step_size = vecs[i].full;
      wait_change(400, n, val);
      check($sformatf("vec%0d_pulses", i), 32'(val), 32'(vecs[i].exp));
      check($sformatf("vec%0d_gap", i), 32'(n), 32'(vecs[i].gap));
    end

    // Speed ping-pong while running full-step CW
    direction = 1'b1;
    step_size = 1'b1;
    for (int i = 0; i < 11; i++) begin
      press_speed();
      check($sformatf("speed%0d_seg_t", i), 32'(sev_seg_t), 32'(spd_exp[i]));
      if (i == 4) begin
        wait_change(400, n, val);
        wait_change(400, n, val);
        check("gap_at_60rpm", 32'(n), 32'd60);
      end
    end
    check("seg_o_running", 32'(sev_seg_o), 32'(7'b1000000));

    // Asynchronous reset mid-run
    @(negedge clk);
    #2 resetb = 1'b0;
    #1;
    check("async_reset_pulses", 32'(pulses_out), 32'h0);
    check("async_reset_seg_t", 32'(sev_seg_t), 32'(7'b1111001));
    @(negedge clk);
    resetb = 1'b1;
    @(negedge clk);
    check("restart_phase", 32'(pulses_out), 32'h1);

    // Quarter turn in half-step mode from idx 0
    on = 1'b0;
    step_size = 1'b0;
    repeat (2) @(negedge clk);
    check("stopped_pulses", 32'(pulses_out), 32'h0);
    quarter = 1'b1;
    @(negedge clk);
    quarter = 1'b0;
    wait_change(20, n, val);
    check("qtr_start", 32'(val), 32'h1);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        quarter   = 1'b1;
        direction = 1'b0;
      end
      wait_change(400, n, val);
      check($sformatf("qtr%0d_pulses", i), 32'(val), 32'(qtr_exp[i]));
      check($sformatf("qtr%0d_gap", i), 32'(n), 32'd180);
    end
    wait_change(400, n, val);
    check("qtr_end_pulses", 32'(val), 32'h0);
    check("qtr_dwell_gap", 32'(n), 32'd180);
    quarter   = 1'b0;
    direction = 1'b1;
    bad = 0;
    repeat (400) begin
      @(negedge clk);
      if (pulses_out != 4'b0000) bad++;
    end
    check("qtr_stays_idle", 32'(bad), 32'd0);

    // Quarter press while running is ignored
    on = 1'b1;
    repeat (5) @(negedge clk);
    quarter = 1'b1;
    repeat (2) @(negedge clk);
    quarter = 1'b0;
    repeat (3) @(negedge clk);
    on = 1'b0;
    repeat (3) @(negedge clk);
    bad = 0;
    repeat (400) begin
      @(negedge clk);
      if (pulses_out != 4'b0000) bad++;
    end
    check("qtr_ignored_when_on", 32'(bad), 32'd0);

    // Speed presses while stopped after reset
    resetb = 1'b0;
    @(negedge clk);
    resetb = 1'b1;
    @(negedge clk);
    repeat (3) press_speed();
    check("three_presses_40rpm", 32'(sev_seg_t), 32'(7'b0011001));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
